// File: rtl/xtea_pkg.sv
// Shared constants, FSM state type and status-register layout for the XTEA Avalon accelerator.
package xtea_pkg;

  localparam int unsigned ROUND_CYCLES = 32;
  localparam logic [31:0] DELTA        = 32'h9E3779B9;

  typedef enum logic [1:0] {
    StIdle,
    StRun0,
    StRun1,
    StDone
  } state_e;

  localparam int unsigned StatusBusyBit  = 0;
  localparam int unsigned StatusDoneBit  = 1;
  localparam int unsigned StatusCountLsb = 4;
  localparam int unsigned StatusPtrLsb   = 8;

endpackage

// File: rtl/xtea_round.sv
// One XTEA cycle: two Feistel rounds (v0 then v1) with the sum advanced by DELTA in between.
module xtea_round
  import xtea_pkg::*;
(
  input  logic [31:0]       v0_i,
  input  logic [31:0]       v1_i,
  input  logic [31:0]       sum_i,
  input  logic [3:0][31:0]  key_i,
  output logic [31:0]       v0_o,
  output logic [31:0]       v1_o,
  output logic [31:0]       sum_o
);

  logic [31:0] v0_next;
  logic [31:0] sum_next;

  always_comb begin
    v0_next  = v0_i + ((((v1_i << 4) ^ (v1_i >> 5)) + v1_i) ^ (sum_i + key_i[sum_i[1:0]]));
    sum_next = sum_i + DELTA;
    v0_o     = v0_next;
    sum_o    = sum_next;
    v1_o     = v1_i + ((((v0_next << 4) ^ (v0_next >> 5)) + v0_next) ^
                       (sum_next + key_i[sum_next[12:11]]));
  end

endmodule

// File: rtl/xtea_avalon_accel.sv
// Avalon-MM slave that encrypts two 64-bit XTEA blocks under one 128-bit key and
// stalls the bus with waitrequest while the core is computing.
module xtea_avalon_accel
  import xtea_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest
);

  localparam int unsigned RndW = $clog2(ROUND_CYCLES);
  localparam logic [RndW-1:0] RndLast = RndW'(ROUND_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [RndW-1:0]  rnd_q, rnd_d;
  logic [7:0][31:0] word_q, word_d;
  logic [3:0][31:0] res_q, res_d;
  logic [31:0]      v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;

  logic [31:0] rnd_v0, rnd_v1, rnd_sum;
  logic        busy, wr_ctl, wr_dat, rd_dat;
  logic [31:0] status;

  xtea_round u_round (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .sum_i (sum_q),
    .key_i (word_q[7:4]),
    .v0_o  (rnd_v0),
    .v1_o  (rnd_v1),
    .sum_o (rnd_sum)
  );

  always_comb begin
    busy   = (state_q == StRun0) || (state_q == StRun1);
    wr_ctl = write & ~address;
    wr_dat = write & address;
    // Write wins over a simultaneous read.
    rd_dat = read & ~write & address;

    waitrequest = (busy & address & (read | write)) | ((state_q == StIdle) & rd_dat);

    status                          = '0;
    status[StatusBusyBit]           = busy;
    status[StatusDoneBit]           = (state_q == StDone);
    status[StatusCountLsb +: 4]     = count_q;
    status[StatusPtrLsb +: 2]       = ptr_q;

    readdata = '0;
    if (read && !waitrequest) begin
      if (!address) begin
        readdata = status;
      end else if (state_q == StDone) begin
        readdata = res_q[ptr_q];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    rnd_d   = rnd_q;
    word_d  = word_q;
    res_d   = res_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;

    unique case (state_q)
      StIdle: begin
        if (wr_dat) begin
          word_d[count_q[2:0]] = writedata;
          count_d              = count_q + 4'd1;
          if (count_q == 4'd7) begin
            state_d = StRun0;
            v0_d    = word_q[0];
            v1_d    = word_q[1];
            sum_d   = '0;
            rnd_d   = '0;
          end
        end
      end
      StRun0, StRun1: begin
        v0_d  = rnd_v0;
        v1_d  = rnd_v1;
        sum_d = rnd_sum;
        rnd_d = rnd_q + 1'b1;
        if (rnd_q == RndLast) begin
          rnd_d = '0;
          if (state_q == StRun0) begin
            res_d[0] = rnd_v0;
            res_d[1] = rnd_v1;
            v0_d     = word_q[2];
            v1_d     = word_q[3];
            sum_d    = '0;
            state_d  = StRun1;
          end else begin
            res_d[2] = rnd_v0;
            res_d[3] = rnd_v1;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (wr_dat) begin
          word_d[0] = writedata;
          count_d   = 4'd1;
          ptr_d     = '0;
          state_d   = StIdle;
        end else if (rd_dat) begin
          ptr_d = ptr_q + 2'd1;
          if (ptr_q == 2'd3) begin
            count_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Soft clear also aborts a running computation; results are left intact.
    if (wr_ctl && writedata[0]) begin
      state_d = StIdle;
      count_d = '0;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      ptr_q   <= '0;
      rnd_q   <= '0;
      word_q  <= '0;
      res_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      rnd_q   <= rnd_d;
      word_q  <= word_d;
      res_q   <= res_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_xtea_avalon_accel.sv
// Scoreboard bench for xtea_avalon_accel: reads queue their expected data, a negedge
// monitor pops and compares whenever a read completes.
module tb_xtea_avalon_accel;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        address = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  localparam int Budget = 200;

  // Word 0 is D0 ... word 7 is K3.
  localparam logic [7:0][31:0] VecA = {32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203,
                                       32'h45464748, 32'h41424344, 32'h45464748, 32'h41424344};
  localparam logic [7:0][31:0] VecZ = '0;
  localparam logic [63:0] CipA = {32'h497DF3D0, 32'h72612CB5};
  localparam logic [63:0] CipZ = {32'hDEE9D4D8, 32'hF7131ED9};

  xtea_avalon_accel dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (read && !write && !waitrequest) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got %08h expected no read", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic addr, input logic [31:0] data);
    int n;
    address   = addr;
    writedata = data;
    write     = 1'b1;
    n = 0;
    @(negedge clk);
    while (waitrequest && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (waitrequest) begin
      checks++;
      failures++;
      $display("FAIL write_timeout: got waitrequest=1 expected 0");
    end
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic bus_read(input logic addr, input logic [31:0] exp, input string name,
                          output int stalls);
    exp_q.push_back(exp);
    name_q.push_back(name);
    address = addr;
    read    = 1'b1;
    stalls  = 0;
    @(negedge clk);
    while (waitrequest && stalls < Budget) begin
      @(negedge clk);
      stalls++;
    end
    if (waitrequest) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got waitrequest=1 expected 0", name);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic rd(input logic addr, input logic [31:0] exp, input string name);
    int s;
    bus_read(addr, exp, name, s);
  endtask

  task automatic load(input logic [7:0][31:0] w, input int first);
    for (int i = first; i < 8; i++) bus_write(1'b1, w[i]);
  endtask

  task automatic read_results(input logic [63:0] c, input bit expect_stall);
    int s;
    bus_read(1'b1, c[63:32], "c0", s);
    check("c0_stall_cycles", s, expect_stall ? 32'd64 : 32'd0);
    bus_read(1'b1, c[31:0], "c1", s);
    bus_read(1'b1, c[63:32], "c2", s);
    bus_read(1'b1, c[31:0], "c3", s);
    rd(1'b0, 32'h0, "status_idle_after_c3");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd(1'b0, 32'h0, "status_after_reset");

    // Standard vector, polling status through the whole computation.
    load(VecA, 0);
    for (int i = 0; i < 64; i++) rd(1'b0, 32'h81, "status_busy");
    rd(1'b0, 32'h82, "status_done");
    read_results(CipA, 1'b0);

    // All-zero vector, read stalls from right after the 8th write.
    load(VecZ, 0);
    read_results(CipZ, 1'b1);

    // Soft clear after a partial load.
    load(VecA, 5);
    rd(1'b0, 32'h30, "status_count3");
    bus_write(1'b0, 32'h1);
    rd(1'b0, 32'h0, "status_cleared");
    load(VecA, 0);
    read_results(CipA, 1'b1);

    // A data write in DONE restarts loading with that word as D0.
    load(VecA, 0);
    repeat (70) @(posedge clk);
    #1;
    rd(1'b0, 32'h82, "status_done_wait");
    bus_write(1'b1, 32'h0);
    rd(1'b0, 32'h10, "status_done_rewrite");
    load(VecZ, 1);
    read_results(CipZ, 1'b1);

    // Reset asserted during RUN1.
    load(VecA, 0);
    repeat (40) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_readdata", readdata, 32'h0);
    check("midrun_reset_waitrequest", {31'b0, waitrequest}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    rd(1'b0, 32'h0, "status_after_midrun_reset");
    load(VecA, 0);
    read_results(CipA, 1'b1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
